mfx_control_sequencer: RTL

// Hardwired fetch/execute sequencer for register-from-special-register moves (mfhi, mflo, and
// up to NUM_SRC sources). Drives datapath/memory control strobes for fetch T0-T2 and move T3,

---
 rtl/mfx_control_sequencer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/mfx_control_sequencer.sv
// mfx_control_sequencer: hardwired fetch/execute sequencer for register-from-special-register
// moves. Moore strobes are decoded from the registered state. In T3 the source select is
// decoded combinationally from the freshly loaded IR opcode.
module mfx_control_sequencer #(
    parameter int                          OPCODE_W    = 5,
    parameter int                          NUM_SRC     = 2,
    parameter logic [NUM_SRC*OPCODE_W-1:0] SRC_OPCODES = {5'b01011, 5'b00011},
    parameter int                          MEM_TIMEOUT = 15,
    parameter int                          COUNT_W     = 16
) (
    input  logic                Clock,
    input  logic                clear,
    input  logic                start,
    input  logic                continuous,
    input  logic                stop,
    input  logic                err_clr,
    input  logic                memory_done,
    input  logic [OPCODE_W-1:0] ir_opcode,
    output logic                PCout,
    output logic                IncPC,
    output logic                MARin,
    output logic                Zin,
    output logic                Zlo_out,
    output logic                PCin,
    output logic                MDRin,
    output logic                Mem_Read,
    output logic                Mem_enable512x32,
    output logic                MDRout,
    output logic                IRin,
    output logic                Gra,
    output logic                Rin,
    output logic [NUM_SRC-1:0]  src_out,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic                mem_timeout,
    output logic [COUNT_W-1:0]  instr_count
);

    localparam int                WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T1W  = 3'd3,
        S_T2   = 3'd4,
        S_T3   = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t               state_r;
    state_t               next_state_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic                 done_r;
    logic                 illegal_r;
    logic                 mem_timeout_r;
    logic [COUNT_W-1:0]   count_r;
    logic [NUM_SRC-1:0]   src_sel_s;
    logic                 match_s;
    logic                 retire_s;
    logic                 loop_s;
    logic                 timeout_s;

    assign retire_s  = (state_r == S_T3) && match_s;
    assign loop_s    = continuous && !stop;
    assign timeout_s = (state_r == S_T1W) && !memory_done && (wait_cnt_r == WAIT_LAST);

    assign done        = done_r;
    assign illegal     = illegal_r;
    assign mem_timeout = mem_timeout_r;
    assign instr_count = count_r;

    // Match the IR opcode against the source table; the lowest matching index wins.
    always_comb begin
        src_sel_s = '0;
        match_s   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!match_s && (ir_opcode == SRC_OPCODES[i*OPCODE_W +: OPCODE_W])) begin
                src_sel_s[i] = 1'b1;
                match_s      = 1'b1;
            end else begin
                // earlier entry already matched, or this entry differs
            end
        end
    end

    // Next-state selection and Moore strobe decode from the current state.
    always_comb begin
        next_state_s     = state_r;
        PCout            = 1'b0;
        IncPC            = 1'b0;
        MARin            = 1'b0;
        Zin              = 1'b0;
        Zlo_out          = 1'b0;
        PCin             = 1'b0;
        MDRin            = 1'b0;
        Mem_Read         = 1'b0;
        Mem_enable512x32 = 1'b0;
        MDRout           = 1'b0;
        IRin             = 1'b0;
        Gra              = 1'b0;
        Rin              = 1'b0;
        src_out          = '0;
        busy             = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_state_s = S_T0;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_T0: begin
                busy         = 1'b1;
                PCout        = 1'b1;
                IncPC        = 1'b1;
                MARin        = 1'b1;
                Zin          = 1'b1;
                next_state_s = S_T1;
            end
            S_T1: begin
                busy             = 1'b1;
                Zlo_out          = 1'b1;
                PCin             = 1'b1;
                MDRin            = 1'b1;
                Mem_Read         = 1'b1;
                Mem_enable512x32 = 1'b1;
                if (memory_done) begin
                    next_state_s = S_T2;
                end else begin
                    next_state_s = S_T1W;
                end
            end
            S_T1W: begin
                busy             = 1'b1;
                MDRin            = 1'b1;
                Mem_Read         = 1'b1;
                Mem_enable512x32 = 1'b1;
                if (memory_done) begin
                    next_state_s = S_T2;
                end else if (timeout_s) begin
                    next_state_s = S_ERR;
                end else begin
                    next_state_s = S_T1W;
                end
            end
            S_T2: begin
                busy         = 1'b1;
                MDRout       = 1'b1;
                IRin         = 1'b1;
                next_state_s = S_T3;
            end
            S_T3: begin
                busy = 1'b1;
                if (match_s) begin
                    Gra     = 1'b1;
                    Rin     = 1'b1;
                    src_out = src_sel_s;
                    if (loop_s) begin
                        next_state_s = S_T0;
                    end else begin
                        next_state_s = S_IDLE;
                    end
                end else begin
                    next_state_s = S_ERR;
                end
            end
            S_ERR: begin
                if (err_clr) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_ERR;
                end
            end
            default: begin
                next_state_s = S_IDLE;
            end
        endcase
    end

    // State register, memory wait counter, sticky fault flags, done pulse and retire count.
    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_r       <= S_IDLE;
            wait_cnt_r    <= '0;
            done_r        <= 1'b0;
            illegal_r     <= 1'b0;
            mem_timeout_r <= 1'b0;
            count_r       <= '0;
        end else begin
            state_r <= next_state_s;
            if ((state_r == S_T1W) && !memory_done && !timeout_s) begin
                wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
            end else begin
                wait_cnt_r <= '0;
            end
            done_r <= retire_s && !loop_s;
            if (retire_s) begin
                count_r <= count_r + COUNT_W'(1);
            end else begin
                count_r <= count_r;
            end
            if ((state_r == S_ERR) && err_clr) begin
                illegal_r     <= 1'b0;
                mem_timeout_r <= 1'b0;
            end else begin
                if ((state_r == S_T3) && !match_s) begin
                    illegal_r <= 1'b1;
                end else begin
                    illegal_r <= illegal_r;
                end
                if (timeout_s) begin
                    mem_timeout_r <= 1'b1;
                end else begin
                    mem_timeout_r <= mem_timeout_r;
                end
            end
        end
    end

endmodule
